brush_color_mapper: RTL and testbench

BRUSH_COLOR_MAPPER -- requirements
Module: brush_color_mapper

---
 rtl/brush_color_mapper_pkg.sv | 33 +++
 rtl/brush_color_mapper_if.sv | 46 ++++
 rtl/brush_color_mapper_brush_hit.sv | 76 +++++++
 rtl/brush_color_mapper.sv | 166 ++++++++++++++++
 tb/tb_brush_color_mapper.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/brush_color_mapper_pkg.sv
// paint_pkg: shared colour/brush types and the default canvas geometry and
// colours used by brush_color_mapper and its brush_hit slices.
package paint_pkg;

  localparam int COORD_W_DEF   = 10;
  localparam int CANVAS_X0_DEF = 60;
  localparam int CANVAS_X1_DEF = 580;
  localparam int CANVAS_Y0_DEF = 60;
  localparam int CANVAS_Y1_DEF = 420;

  localparam logic [23:0] BORDER_RGB_DEF = 24'h888888;
  localparam logic [23:0] BG_RGB_DEF     = 24'h000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Brush slot at the default coordinate width.
  typedef struct packed {
    logic                   en;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] size;
    rgb_t                   rgb;
  } brush_t;

  function automatic rgb_t to_rgb(input logic [23:0] v);
    return rgb_t'(v);
  endfunction

endpackage

// File: rtl/brush_color_mapper_if.sv
// Pixel stream and brush-table write bus for brush_color_mapper.
// master = pixel/config source, slave = the mapper.
interface brush_color_mapper_if
  import paint_pkg::*;
#(
  parameter int NUM_BRUSH = 4,
  parameter int COORD_W   = COORD_W_DEF
);
  localparam int IDX_W = (NUM_BRUSH > 1) ? $clog2(NUM_BRUSH) : 1;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               pix_valid_in;
  logic               frame_start;

  logic               brush_we;
  logic [IDX_W-1:0]   brush_idx;
  logic               brush_en;
  logic [COORD_W-1:0] brush_x;
  logic [COORD_W-1:0] brush_y;
  logic [COORD_W-1:0] brush_size;
  logic [7:0]         brush_r;
  logic [7:0]         brush_g;
  logic [7:0]         brush_b;

  logic [7:0]         Red;
  logic [7:0]         Green;
  logic [7:0]         Blue;
  logic               pix_valid_out;
  logic [3:0]         hit_idx;

  modport master (
    output DrawX, DrawY, pix_valid_in, frame_start,
    output brush_we, brush_idx, brush_en, brush_x, brush_y, brush_size,
    output brush_r, brush_g, brush_b,
    input  Red, Green, Blue, pix_valid_out, hit_idx
  );

  modport slave (
    input  DrawX, DrawY, pix_valid_in, frame_start,
    input  brush_we, brush_idx, brush_en, brush_x, brush_y, brush_size,
    input  brush_r, brush_g, brush_b,
    output Red, Green, Blue, pix_valid_out, hit_idx
  );

endinterface

// File: rtl/brush_color_mapper_brush_hit.sv
// brush_hit: stages 1-2 of the mapper for one circular brush.
// Stage 1 registers the signed offsets from the centre, stage 2 registers
// the inside-circle decision. Squares are formed at 2*COORD_W+3 bits so the
// largest sum of squares cannot wrap.
module brush_hit
  import paint_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               en,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] bsize,
  input  rgb_t               rgb_in,
  output logic               hit,
  output rgb_t               rgb_out
);

  localparam int DW = COORD_W + 1;
  localparam int SW = 2 * COORD_W + 3;

  logic signed [DW-1:0] dist_x;
  logic signed [DW-1:0] dist_y;
  logic [COORD_W-1:0]   size_s1;
  logic                 en_s1;
  rgb_t                 rgb_s1;

  logic signed [SW-1:0] dx_e;
  logic signed [SW-1:0] dy_e;
  logic signed [SW-1:0] sq_x;
  logic signed [SW-1:0] sq_y;
  logic [SW-1:0]        size_e;
  logic [SW-1:0]        sq_sum;
  logic [SW-1:0]        sz_sq;

  // Stage 1: offsets from the brush centre, with the slot snapshot riding along.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dist_x  <= '0;
      dist_y  <= '0;
      size_s1 <= '0;
      en_s1   <= 1'b0;
      rgb_s1  <= '0;
    end else begin
      dist_x  <= $signed({1'b0, draw_x}) - $signed({1'b0, bx});
      dist_y  <= $signed({1'b0, draw_y}) - $signed({1'b0, by});
      size_s1 <= bsize;
      en_s1   <= en;
      rgb_s1  <= rgb_in;
    end
  end

  assign dx_e   = {{(SW-DW){dist_x[DW-1]}}, dist_x};
  assign dy_e   = {{(SW-DW){dist_y[DW-1]}}, dist_y};
  assign sq_x   = dx_e * dx_e;
  assign sq_y   = dy_e * dy_e;
  assign sq_sum = $unsigned(sq_x + sq_y);
  assign size_e = {{(SW-COORD_W){1'b0}}, size_s1};
  assign sz_sq  = size_e * size_e;

  // Stage 2: inside-or-on-circle decision for an enabled slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit     <= 1'b0;
      rgb_out <= '0;
    end else begin
      hit     <= en_s1 && (sq_sum <= sz_sq);
      rgb_out <= rgb_s1;
    end
  end

endmodule

// File: rtl/brush_color_mapper.sv
// brush_color_mapper: 3-stage pixel colour pipeline over NUM_BRUSH circular
// brushes with a canvas border. Border wins, then the lowest-index hitting
// brush, then the background.
// Build option: BRUSH_SHADOW_EN -- brush writes go to a shadow table that is
// copied to the active table when frame_start is high; otherwise writes go
// straight to the active table and frame_start is unused.
module brush_color_mapper
  import paint_pkg::*;
#(
  parameter int          NUM_BRUSH  = 4,
  parameter int          COORD_W    = COORD_W_DEF,
  parameter int          CANVAS_X0  = CANVAS_X0_DEF,
  parameter int          CANVAS_X1  = CANVAS_X1_DEF,
  parameter int          CANVAS_Y0  = CANVAS_Y0_DEF,
  parameter int          CANVAS_Y1  = CANVAS_Y1_DEF,
  parameter logic [23:0] BORDER_RGB = BORDER_RGB_DEF,
  parameter logic [23:0] BG_RGB     = BG_RGB_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  brush_color_mapper_if.slave  bus
);

  localparam int IDX_W = (NUM_BRUSH > 1) ? $clog2(NUM_BRUSH) : 1;

  localparam logic [COORD_W-1:0] CX0 = COORD_W'(CANVAS_X0);
  localparam logic [COORD_W-1:0] CX1 = COORD_W'(CANVAS_X1);
  localparam logic [COORD_W-1:0] CY0 = COORD_W'(CANVAS_Y0);
  localparam logic [COORD_W-1:0] CY1 = COORD_W'(CANVAS_Y1);

  // Same fields as paint_pkg::brush_t, sized to this instance's COORD_W.
  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] size;
    rgb_t               rgb;
  } slot_t;

  slot_t act_tbl [NUM_BRUSH];
  slot_t wr_slot;
  logic  wr_ok;

  assign wr_slot = '{en: bus.brush_en, x: bus.brush_x, y: bus.brush_y,
                     size: bus.brush_size,
                     rgb: '{r: bus.brush_r, g: bus.brush_g, b: bus.brush_b}};
  assign wr_ok   = bus.brush_we &&
                   ({1'b0, bus.brush_idx} < (IDX_W+1)'(NUM_BRUSH));

`ifdef BRUSH_SHADOW_EN
  slot_t shd_tbl  [NUM_BRUSH];
  slot_t shd_next [NUM_BRUSH];

  // Shadow table with this cycle's write merged in.
  always_comb begin
    shd_next = shd_tbl;
    if (wr_ok) begin
      for (int i = 0; i < NUM_BRUSH; i++) begin
        if (bus.brush_idx == IDX_W'(i)) shd_next[i] = wr_slot;
      end
    end
  end

  // Shadow captures writes; frame_start publishes it, same-cycle write included.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BRUSH; i++) begin
        shd_tbl[i] <= '0;
        act_tbl[i] <= '0;
      end
    end else begin
      shd_tbl <= shd_next;
      if (bus.frame_start) act_tbl <= shd_next;
    end
  end
`else
  // Writes land directly in the active table.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BRUSH; i++) act_tbl[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_BRUSH; i++) begin
        if (bus.brush_idx == IDX_W'(i)) act_tbl[i] <= wr_slot;
      end
    end
  end
`endif

  logic [NUM_BRUSH-1:0] hit_s2;
  rgb_t                 rgb_s2 [NUM_BRUSH];

  for (genvar gi = 0; gi < NUM_BRUSH; gi++) begin : g_brush
    brush_hit #(.COORD_W(COORD_W)) u_hit (
      .Clk     (Clk),
      .Reset   (Reset),
      .draw_x  (bus.DrawX),
      .draw_y  (bus.DrawY),
      .en      (act_tbl[gi].en),
      .bx      (act_tbl[gi].x),
      .by      (act_tbl[gi].y),
      .bsize   (act_tbl[gi].size),
      .rgb_in  (act_tbl[gi].rgb),
      .hit     (hit_s2[gi]),
      .rgb_out (rgb_s2[gi])
    );
  end

  logic border_in;
  logic border_s1, border_s2;
  logic v_s1, v_s2;

  assign border_in = (bus.DrawX < CX0) || (bus.DrawX > CX1) ||
                     (bus.DrawY < CY0) || (bus.DrawY > CY1);

  // Border flag and valid travel alongside the per-brush stages.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      border_s1 <= 1'b0;
      border_s2 <= 1'b0;
      v_s1      <= 1'b0;
      v_s2      <= 1'b0;
    end else begin
      border_s1 <= border_in;
      border_s2 <= border_s1;
      v_s1      <= bus.pix_valid_in;
      v_s2      <= v_s1;
    end
  end

  rgb_t       sel_rgb;
  logic [3:0] sel_idx;

  // Priority select: walk downwards so the lowest hitting index wins.
  always_comb begin
    sel_rgb = to_rgb(BG_RGB);
    sel_idx = 4'hF;
    for (int i = NUM_BRUSH - 1; i >= 0; i--) begin
      if (hit_s2[i]) begin
        sel_rgb = rgb_s2[i];
        sel_idx = 4'(i);
      end
    end
    if (border_s2) begin
      sel_rgb = to_rgb(BORDER_RGB);
      sel_idx = 4'hF;
    end
  end

  // Stage 3: registered colour, index and valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.Red           <= 8'h00;
      bus.Green         <= 8'h00;
      bus.Blue          <= 8'h00;
      bus.hit_idx       <= 4'hF;
      bus.pix_valid_out <= 1'b0;
    end else begin
      bus.Red           <= sel_rgb.r;
      bus.Green         <= sel_rgb.g;
      bus.Blue          <= sel_rgb.b;
      bus.hit_idx       <= sel_idx;
      bus.pix_valid_out <= v_s2;
    end
  end

endmodule

// File: tb/tb_brush_color_mapper.sv
// Directed bench for brush_color_mapper (default 4 brushes, 10-bit coords).
module tb_brush_color_mapper;
  import paint_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  brush_color_mapper_if #(.NUM_BRUSH(4), .COORD_W(10)) bus ();

  brush_color_mapper #(.NUM_BRUSH(4), .COORD_W(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld,
                           input logic [23:0] rgb, input logic [3:0] idx);
    check({tag, "_valid"}, 32'(bus.pix_valid_out), 32'(vld));
    check({tag, "_rgb"}, 32'({bus.Red, bus.Green, bus.Blue}), 32'(rgb));
    check({tag, "_idx"}, 32'(bus.hit_idx), 32'(idx));
  endtask

  task automatic write_brush(input int idx, input logic en, input int x,
                             input int y, input int size,
                             input logic [23:0] rgb, input logic fs);
    @(posedge Clk); #1;
    bus.brush_we    = 1'b1;
    bus.brush_idx   = 2'(idx);
    bus.brush_en    = en;
    bus.brush_x     = 10'(x);
    bus.brush_y     = 10'(y);
    bus.brush_size  = 10'(size);
    bus.brush_r     = rgb[23:16];
    bus.brush_g     = rgb[15:8];
    bus.brush_b     = rgb[7:0];
    bus.frame_start = fs;
    @(posedge Clk); #1;
    bus.brush_we    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  // One pixel, checked exactly 3 cycles after it is presented.
  task automatic pix(input int x, input int y, input logic vld,
                     input logic [23:0] rgb, input logic [3:0] idx,
                     input string tag);
    @(posedge Clk); #1;
    bus.DrawX        = 10'(x);
    bus.DrawY        = 10'(y);
    bus.pix_valid_in = vld;
    @(posedge Clk); #1;
    bus.pix_valid_in = 1'b0;
    @(posedge Clk); #1;
    check({tag, "_early"}, 32'(bus.pix_valid_out), 32'(0));
    @(posedge Clk); #1;
    if (vld) check_out(tag, 1'b1, rgb, idx);
    else     check({tag, "_valid"}, 32'(bus.pix_valid_out), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fs;
`ifdef BRUSH_SHADOW_EN
    fs = 1'b1;
`else
    fs = 1'b0;
`endif
    checks   = 0;
    failures = 0;
    Reset            = 1'b1;
    bus.DrawX        = '0;
    bus.DrawY        = '0;
    bus.pix_valid_in = 1'b0;
    bus.frame_start  = 1'b0;
    bus.brush_we     = 1'b0;
    bus.brush_idx    = '0;
    bus.brush_en     = 1'b0;
    bus.brush_x      = '0;
    bus.brush_y      = '0;
    bus.brush_size   = '0;
    bus.brush_r      = '0;
    bus.brush_g      = '0;
    bus.brush_b      = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_out("reset", 1'b0, 24'h000000, 4'hF);
    Reset = 1'b0;

    pix(300, 300, 1'b1, 24'h000000, 4'hF, "empty");

    write_brush(0, 1'b1, 200, 200, 10, 24'hFF0000, fs);
    pix(205, 205, 1'b1, 24'hFF0000, 4'h0, "b0_in");
    pix(210, 210, 1'b1, 24'h000000, 4'hF, "b0_out");
    pix(210, 200, 1'b1, 24'hFF0000, 4'h0, "b0_edge");
    pix(211, 200, 1'b1, 24'h000000, 4'hF, "b0_past");
    pix(205, 205, 1'b0, 24'h000000, 4'hF, "novalid");

    write_brush(3, 1'b1, 60, 80, 25, 24'h123456, fs);
    write_brush(2, 1'b1, 580, 420, 5, 24'h0000FF, fs);
    pix(59, 100, 1'b1, 24'h888888, 4'hF, "border_left");
    pix(60, 60, 1'b1, 24'h123456, 4'h3, "corner_in");
    pix(580, 420, 1'b1, 24'h0000FF, 4'h2, "corner_max");
    pix(581, 420, 1'b1, 24'h888888, 4'hF, "border_right");
    pix(580, 421, 1'b1, 24'h888888, 4'hF, "border_bottom");

    write_brush(2, 1'b1, 300, 300, 10, 24'h0000FF, fs);
    write_brush(1, 1'b1, 305, 300, 10, 24'h00FF00, fs);
    pix(300, 300, 1'b1, 24'h00FF00, 4'h1, "overlap");
    write_brush(1, 1'b0, 305, 300, 10, 24'h00FF00, fs);
    pix(300, 300, 1'b1, 24'h0000FF, 4'h2, "overlap_dis");

`ifdef BRUSH_SHADOW_EN
    write_brush(0, 1'b1, 200, 200, 10, 24'h00FFFF, 1'b0);
    pix(200, 200, 1'b1, 24'hFF0000, 4'h0, "shadow_old");
    @(posedge Clk); #1;
    bus.frame_start = 1'b1;
    @(posedge Clk); #1;
    bus.frame_start = 1'b0;
    pix(200, 200, 1'b1, 24'h00FFFF, 4'h0, "shadow_new");
`else
    write_brush(0, 1'b1, 200, 200, 10, 24'h00FFFF, 1'b0);
    pix(200, 200, 1'b1, 24'h00FFFF, 4'h0, "direct_new");
`endif

    write_brush(0, 1'b1, 100, 100, 0, 24'hAABBCC, fs);
    pix(100, 100, 1'b1, 24'hAABBCC, 4'h0, "size0_ctr");
    pix(101, 100, 1'b1, 24'h000000, 4'hF, "size0_x");
    pix(100, 99, 1'b1, 24'h000000, 4'hF, "size0_y");

    write_brush(1, 1'b1, 1023, 1023, 1023, 24'h11FF11, fs);
    pix(102, 100, 1'b1, 24'h000000, 4'hF, "no_wrap");
    write_brush(1, 1'b1, 0, 0, 1023, 24'h11FF11, fs);
    pix(580, 420, 1'b1, 24'h11FF11, 4'h1, "big_hit");
    pix(1023, 1023, 1'b1, 24'h888888, 4'hF, "max_coord");

    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      if (k >= 3 && k <= 5) check_out("pre_rst", 1'b1, 24'hAABBCC, 4'h0);
      if (k >= 6 && k <= 8) check_out("flush", 1'b0, 24'h000000, 4'hF);
      if (k == 9)           check_out("post_rst", 1'b1, 24'h000000, 4'hF);
      bus.DrawX        = 10'd100;
      bus.DrawY        = 10'd100;
      bus.pix_valid_in = 1'b1;
      Reset            = (k == 5);
    end
    bus.pix_valid_in = 1'b0;
    pix(200, 200, 1'b1, 24'h000000, 4'hF, "tbl_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
